// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one magnitude bit per cycle.
// A conversion takes W cycles; the result and sign are held until the next done.
module seq_bin_to_bcd #(
    parameter int W      = 16,
    parameter int SIGNED = 1,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

    state_t              state;
    logic [W-1:0]        mag;
    logic [4*DIGITS-1:0] work;
    logic [CW-1:0]       cnt;
    logic                neg;

    logic                in_neg;
    logic [W-1:0]        in_mag;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] work_nxt;

    // Operand magnitude; negating -2^(W-1) wraps to 2^(W-1), which is the wanted value.
    always_comb begin
        in_neg = (SIGNED != 0) && in[W-1];
        in_mag = in_neg ? (~in + W'(1)) : in;
    end

    // One double-dabble step: per-digit add-3 (no inter-digit carry), then shift in the MSB.
    always_comb begin
        adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] > 4'd4) begin
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
        work_nxt = {adj[4*DIGITS-2:0], mag[W-1]};
    end

    // Control FSM with registered outputs; reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            sign  <= 1'b0;
            mag   <= '0;
            work  <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        mag   <= in_mag;
                        neg   <= in_neg;
                        work  <= '0;
                        cnt   <= CW'(W);
                        busy  <= 1'b1;
                        state <= StShift;
                    end
                end
                StShift: begin
                    work <= work_nxt;
                    mag  <= {mag[W-2:0], 1'b0};
                    cnt  <= cnt - CW'(1);
                    // Last shift: publish the freshly shifted value directly.
                    if (cnt == CW'(1)) begin
                        bcd   <= work_nxt;
                        sign  <= neg;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule
